// File: rtl/io_sel_ctrl_pkg.sv
// io_sel_ctrl_pkg
//   Shared definitions for the I/O function-select controller:
//   register word indices within the 16-byte peripheral window and the
//   2-bit sequencer state encoding.
package io_sel_ctrl_pkg;

  // Word index inside the window (byte offset / 2)
  localparam logic [2:0] REG_SEL_REQ  = 3'd0;  // 0x0
  localparam logic [2:0] REG_DEADTIME = 3'd1;  // 0x2
  localparam logic [2:0] REG_CTRL     = 3'd2;  // 0x4
  localparam logic [2:0] REG_STATUS   = 3'd3;  // 0x6
  localparam logic [2:0] REG_SEL_ACT  = 3'd4;  // 0x8

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BLANK  = 2'b01,
    ST_SWITCH = 2'b10,
    ST_SETTLE = 2'b11
  } seq_state_t;

endpackage

// File: rtl/io_sel_seq.sv
// io_sel_seq
//   Glitch-free function-select sequencer. When the requested pattern
//   differs from the active one, the changing pins have their output
//   enable blanked, a dead time elapses, sel switches, a second dead time
//   elapses, then the enables are restored.
// Ports:
//   mclk, puc_rst   clock, asynchronous active-high reset
//   sel_req         requested select pattern
//   deadtime        dead-time reload value (cycles)
//   sel             active select (registered)
//   oe_mask         output-enable qualifier, 1 = pass (registered)
//   busy            sequencer not idle
//   done_set        one-cycle pulse on the edge that completes a sequence
module io_sel_seq
  import io_sel_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             mclk,
  input  logic             puc_rst,
  input  logic [WIDTH-1:0] sel_req,
  input  logic [7:0]       deadtime,
  output logic [WIDTH-1:0] sel,
  output logic [WIDTH-1:0] oe_mask,
  output logic             busy,
  output logic             done_set
);

  seq_state_t       state;
  logic [7:0]       cnt;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] chg;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      tgt     <= '0;
      chg     <= '0;
      sel     <= '0;
      oe_mask <= '1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_req != sel) begin
            tgt     <= sel_req;
            chg     <= sel_req ^ sel;
            oe_mask <= ~(sel_req ^ sel);
            cnt     <= deadtime;
            state   <= ST_BLANK;
          end
        end
        // The switch action is taken on the edge that ends blanking, so the
        // SWITCH encoding costs no extra cycle (sel lands D+1 cycles after
        // the blank, done D+1 cycles after sel).
        ST_BLANK, ST_SWITCH: begin
          if (state == ST_BLANK && cnt != '0) begin
            cnt <= cnt - 8'd1;
          end else begin
            sel   <= tgt;
            cnt   <= deadtime;
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 8'd1;
          end else begin
            oe_mask <= oe_mask | chg;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    done_set = (state == ST_SETTLE) && (cnt == '0);
  end

endmodule

// File: rtl/io_sel_ctrl.sv
// io_sel_ctrl
//   openMSP430 peripheral owning the per-pin function-select vector of a
//   GPIO/peripheral port pair. Holds the register file, address decode and
//   read mux; the change sequencing lives in io_sel_seq.
// Ports:
//   mclk, puc_rst   clock, asynchronous active-high reset
//   per_addr        peripheral word address
//   per_din         write data
//   per_en          access enable
//   per_we          byte write enables (low byte used)
//   per_dout        read data, 0 when the window is not addressed
//   sel             active function select (0=A, 1=B)
//   oe_mask         output-enable qualifier (1=pass)
//   busy            sequencer not idle
//   irq             level interrupt = done & ie
module io_sel_ctrl
  import io_sel_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter logic [14:0] BASE_ADDR = 15'h01A0
) (
  input  logic             mclk,
  input  logic             puc_rst,
  input  logic [13:0]      per_addr,
  input  logic [15:0]      per_din,
  input  logic             per_en,
  input  logic [1:0]       per_we,
  output logic [15:0]      per_dout,
  output logic [WIDTH-1:0] sel,
  output logic [WIDTH-1:0] oe_mask,
  output logic             busy,
  output logic             irq
);

  logic             reg_hit;
  logic             reg_wr;
  logic [2:0]       reg_idx;
  logic [WIDTH-1:0] sel_req;
  logic [7:0]       deadtime;
  logic             ie;
  logic             done;
  logic             done_set;
  logic             unused_bits;

  always_comb begin
    reg_hit = per_en && (per_addr[13:3] == BASE_ADDR[14:4]);
    reg_idx = per_addr[2:0];
    reg_wr  = reg_hit && per_we[0];
  end

  assign unused_bits = &{1'b0, per_din[15:8], per_we[1]};

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      sel_req  <= '0;
      deadtime <= '0;
      ie       <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (reg_wr && reg_idx == REG_SEL_REQ)  sel_req  <= per_din[WIDTH-1:0];
      if (reg_wr && reg_idx == REG_DEADTIME) deadtime <= per_din[7:0];
      if (reg_wr && reg_idx == REG_CTRL)     ie       <= per_din[0];
      // Completion beats a simultaneous write-1-to-clear
      if (done_set)
        done <= 1'b1;
      else if (reg_wr && reg_idx == REG_STATUS && per_din[1])
        done <= 1'b0;
    end
  end

  io_sel_seq #(
    .WIDTH(WIDTH)
  ) u_seq (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .sel_req (sel_req),
    .deadtime(deadtime),
    .sel     (sel),
    .oe_mask (oe_mask),
    .busy    (busy),
    .done_set(done_set)
  );

  always_comb begin
    per_dout = '0;
    if (reg_hit) begin
      case (reg_idx)
        REG_SEL_REQ:  per_dout = 16'(sel_req);
        REG_DEADTIME: per_dout = 16'(deadtime);
        REG_CTRL:     per_dout = 16'(ie);
        REG_STATUS:   per_dout = {14'd0, done, busy};
        REG_SEL_ACT:  per_dout = 16'(sel);
        default:      per_dout = '0;
      endcase
    end
  end

  assign irq = done & ie;

endmodule

// File: tb/tb_io_sel_ctrl.sv
// tb_io_sel_ctrl
//   Self-checking bench for io_sel_ctrl: register table, hand-timed
//   sequences for the multi-cycle cases, then random bus traffic checked
//   against an edge-counting reference model.
module tb_io_sel_ctrl;

  localparam logic [13:0] BW = 14'h00D0;  // word address of byte 0x01A0

  logic        mclk    = 1'b0;
  logic        puc_rst = 1'b1;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din  = '0;
  logic        per_en   = 1'b0;
  logic [1:0]  per_we   = '0;
  logic [15:0] per_dout;
  logic [7:0]  sel;
  logic [7:0]  oe_mask;
  logic        busy;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  bit auto_chk = 1'b0;

  io_sel_ctrl #(.WIDTH(8), .BASE_ADDR(15'h01A0)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .per_addr(per_addr), .per_din(per_din),
    .per_en(per_en), .per_we(per_we), .per_dout(per_dout), .sel(sel),
    .oe_mask(oe_mask), .busy(busy), .irq(irq)
  );

  always #5 mclk = ~mclk;

  // ---------------- reference model ----------------
  // Phase 0 idle, 1 blanking, 2 settling; m_left counts edges until the
  // phase ends (dead time + 1).
  logic [7:0] m_sel_req = '0, m_dt = '0, m_sel = '0, m_oe = 8'hFF, m_tgt = '0;
  logic       m_ie = 1'b0, m_done = 1'b0;
  int         m_phase = 0, m_left = 0;

  always @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      m_sel_req = '0; m_dt = '0; m_sel = '0; m_oe = 8'hFF; m_tgt = '0;
      m_ie = 1'b0; m_done = 1'b0; m_phase = 0; m_left = 0;
    end else begin
      bit dset, clr, wr;
      int idx;
      dset = 1'b0; clr = 1'b0;
      wr  = per_en && per_we[0] && per_addr >= BW && per_addr <= BW + 14'd7;
      idx = int'(per_addr) - int'(BW);
      if (m_phase == 0) begin
        if (m_sel_req != m_sel) begin
          m_tgt = m_sel_req; m_oe = ~(m_sel_req ^ m_sel);
          m_left = int'(m_dt) + 1; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_left--;
        if (m_left == 0) begin
          m_sel = m_tgt; m_left = int'(m_dt) + 1; m_phase = 2;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_oe = 8'hFF; dset = 1'b1; m_phase = 0;
        end
      end
      if (wr) begin
        case (idx)
          0: m_sel_req = per_din[7:0];
          1: m_dt      = per_din[7:0];
          2: m_ie      = per_din[0];
          3: clr       = per_din[1];
          default: ;
        endcase
      end
      if (dset) m_done = 1'b1;
      else if (clr) m_done = 1'b0;
    end
  end

  function automatic logic [15:0] exp_read(input logic [13:0] a);
    int idx;
    if (a < BW || a > BW + 14'd7) return 16'h0000;
    idx = int'(a) - int'(BW);
    case (idx)
      0: return {8'h00, m_sel_req};
      1: return {8'h00, m_dt};
      2: return {15'h0000, m_ie};
      3: return {14'h0000, m_done, (m_phase != 0)};
      4: return {8'h00, m_sel};
      default: return 16'h0000;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
    if (auto_chk) begin
      check("model sel", {8'h00, sel}, {8'h00, m_sel});
      check("model oe_mask", {8'h00, oe_mask}, {8'h00, m_oe});
      check("model busy", {15'h0, busy}, {15'h0, (m_phase != 0)});
      check("model irq", {15'h0, irq}, {15'h0, (m_done & m_ie)});
    end
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
    per_en = 1'b1; per_we = we; per_addr = a; per_din = d;
    tick();
    per_en = 1'b0; per_we = 2'b00;
  endtask

  task automatic bus_read_chk(input string name, input logic [13:0] a, input logic [15:0] exp);
    per_en = 1'b1; per_we = 2'b00; per_addr = a;
    #1;
    check(name, per_dout, exp);
    per_en = 1'b0;
  endtask

  task automatic wait_while_busy(input string name, input int max);
    int n;
    n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    check(name, {15'h0, busy}, 16'h0000);
  endtask

  typedef struct {
    bit          wr;
    logic [13:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Register table: {write?, address, data, expected read}
    vt.push_back('{1'b0, BW + 14'd0, 16'h0000, 16'h0000});
    vt.push_back('{1'b0, BW + 14'd1, 16'h0000, 16'h0000});
    vt.push_back('{1'b0, BW + 14'd2, 16'h0000, 16'h0000});
    vt.push_back('{1'b0, BW + 14'd3, 16'h0000, 16'h0000});
    vt.push_back('{1'b0, BW + 14'd4, 16'h0000, 16'h0000});
    vt.push_back('{1'b1, BW + 14'd1, 16'hFF5A, 16'h0000});
    vt.push_back('{1'b0, BW + 14'd1, 16'h0000, 16'h005A});
    vt.push_back('{1'b1, BW + 14'd2, 16'hFFFF, 16'h0000});
    vt.push_back('{1'b0, BW + 14'd2, 16'h0000, 16'h0001});
    vt.push_back('{1'b1, BW + 14'd2, 16'h0000, 16'h0000});
    vt.push_back('{1'b0, BW + 14'd2, 16'h0000, 16'h0000});
    vt.push_back('{1'b1, BW + 14'd5, 16'h1234, 16'h0000});
    vt.push_back('{1'b0, BW + 14'd5, 16'h0000, 16'h0000});
    vt.push_back('{1'b1, BW + 14'd8, 16'h00AA, 16'h0000});
    vt.push_back('{1'b0, BW + 14'd8, 16'h0000, 16'h0000});
    vt.push_back('{1'b0, BW + 14'd0, 16'h0000, 16'h0000});
    vt.push_back('{1'b1, BW + 14'd1, 16'h0000, 16'h0000});
    vt.push_back('{1'b0, BW + 14'd1, 16'h0000, 16'h0000});

    // Reset
    repeat (3) tick();
    puc_rst = 1'b0;
    tick();
    auto_chk = 1'b1;
    check("reset sel", {8'h00, sel}, 16'h0000);
    check("reset oe_mask", {8'h00, oe_mask}, 16'h00FF);
    check("reset busy", {15'h0, busy}, 16'h0000);
    check("reset irq", {15'h0, irq}, 16'h0000);

    foreach (vt[i]) begin
      if (vt[i].wr) bus_write(vt[i].addr, vt[i].data, 2'b11);
      else bus_read_chk($sformatf("table[%0d]", i), vt[i].addr, vt[i].exp);
    end

    // DEADTIME=3, 00 -> 05
    bus_write(BW + 14'd1, 16'h0003, 2'b11);
    bus_write(BW + 14'd0, 16'h0005, 2'b11);
    check("d3 T0 oe", {8'h00, oe_mask}, 16'h00FF);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("d3 oe T0+%0d", k), {8'h00, oe_mask}, (k < 9) ? 16'h00FA : 16'h00FF);
      check($sformatf("d3 sel T0+%0d", k), {8'h00, sel}, (k >= 5) ? 16'h0005 : 16'h0000);
      check($sformatf("d3 busy T0+%0d", k), {15'h0, busy}, (k < 9) ? 16'h0001 : 16'h0000);
    end
    bus_read_chk("d3 status done", BW + 14'd3, 16'h0002);
    bus_read_chk("d3 sel_act", BW + 14'd4, 16'h0005);
    bus_write(BW + 14'd3, 16'h0002, 2'b11);
    bus_read_chk("d3 status cleared", BW + 14'd3, 16'h0000);

    // DEADTIME=0, ie=1, 05 -> 80
    bus_write(BW + 14'd1, 16'h0000, 2'b11);
    bus_write(BW + 14'd2, 16'h0001, 2'b11);
    bus_write(BW + 14'd0, 16'h0080, 2'b11);
    tick();
    check("d0 oe T0+1", {8'h00, oe_mask}, 16'h007A);
    check("d0 sel T0+1", {8'h00, sel}, 16'h0005);
    tick();
    check("d0 sel T0+2", {8'h00, sel}, 16'h0080);
    check("d0 irq T0+2", {15'h0, irq}, 16'h0000);
    tick();
    check("d0 irq T0+3", {15'h0, irq}, 16'h0001);
    check("d0 oe T0+3", {8'h00, oe_mask}, 16'h00FF);
    bus_write(BW + 14'd3, 16'h0002, 2'b11);
    check("d0 irq after W1C", {15'h0, irq}, 16'h0000);

    // Request changed during BLANK
    bus_write(BW + 14'd1, 16'h0002, 2'b11);
    bus_write(BW + 14'd0, 16'h0000, 2'b11);
    tick();
    wait_while_busy("to00 idle", 50);
    check("to00 sel", {8'h00, sel}, 16'h0000);
    bus_write(BW + 14'd0, 16'h000F, 2'b11);
    tick();
    check("0F blank oe", {8'h00, oe_mask}, 16'h00F0);
    bus_write(BW + 14'd0, 16'h00F0, 2'b11);
    wait_while_busy("0F first idle", 50);
    check("0F first sel", {8'h00, sel}, 16'h000F);
    check("0F first oe", {8'h00, oe_mask}, 16'h00FF);
    tick();
    check("F0 second busy", {15'h0, busy}, 16'h0001);
    check("F0 second oe", {8'h00, oe_mask}, 16'h0000);
    wait_while_busy("F0 second idle", 50);
    check("F0 final sel", {8'h00, sel}, 16'h00F0);

    // Async reset during SETTLE
    bus_write(BW + 14'd0, 16'h0033, 2'b11);
    n = 0;
    while (sel !== 8'h33 && n < 50) begin
      tick();
      n++;
    end
    check("settle sel reached", {8'h00, sel}, 16'h0033);
    check("settle oe", {8'h00, oe_mask}, 16'h003C);
    check("settle busy", {15'h0, busy}, 16'h0001);
    #2 puc_rst = 1'b1;
    #1;
    check("arst sel", {8'h00, sel}, 16'h0000);
    check("arst oe", {8'h00, oe_mask}, 16'h00FF);
    check("arst busy", {15'h0, busy}, 16'h0000);
    #1 puc_rst = 1'b0;
    tick();
    bus_read_chk("arst deadtime", BW + 14'd1, 16'h0000);

    // done set and W1C on the same edge; then no-op request
    bus_write(BW + 14'd0, 16'h0001, 2'b11);
    tick();
    tick();
    bus_write(BW + 14'd3, 16'h0002, 2'b11);
    bus_read_chk("set beats w1c", BW + 14'd3, 16'h0002);
    bus_write(BW + 14'd0, 16'h0001, 2'b11);
    tick();
    check("noop busy", {15'h0, busy}, 16'h0000);
    tick();
    bus_read_chk("noop status", BW + 14'd3, 16'h0002);

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      int r;
      logic [13:0] a;
      r = $urandom_range(0, 9);
      case (r)
        0, 1: bus_write(BW + 14'd0, 16'($urandom), 2'b11);
        2: bus_write(BW + 14'd1, 16'($urandom_range(0, 4)), 2'($urandom));
        3: bus_write(BW + 14'd2, 16'($urandom), 2'b11);
        4: bus_write(BW + 14'd3, 16'($urandom), 2'b11);
        5: begin
          a = BW + 14'($urandom_range(0, 7));
          bus_read_chk("rand read", a, exp_read(a));
          tick();
        end
        6: bus_write(14'h00E0 + 14'($urandom_range(0, 7)), 16'($urandom), 2'b11);
        default: tick();
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
